// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data unified-memory arbiter.
package rv32i_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arb_state_e;

   localparam logic       ARB_OWNER_IF = 1'b0;
   localparam logic       ARB_OWNER_DM = 1'b1;
   localparam logic [3:0] MEM_BE_ALL   = 4'hF;
   localparam int         LAT_CNT_W    = 4;

   function automatic arb_state_e owner_state(input logic owner);
      return (owner == ARB_OWNER_DM) ? ARB_BUSY_DM : ARB_BUSY_IF;
   endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
interface rv32i_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic [3:0]        dm_be_i;
   logic              dm_gnt_o;
   logic              dm_rvalid_o;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [3:0]        mem_be_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              stall_o;
   logic [31:0]       perf_conflict_o;
   logic [31:0]       perf_if_wait_o;

   modport slave (
      input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i, mem_rdata_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
             stall_o, perf_conflict_o, perf_if_wait_o
   );

   modport master (
      output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i, mem_rdata_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
             stall_o, perf_conflict_o, perf_if_wait_o
   );
endinterface

// File: rtl/rv32i_mem_arb_lat_cnt.sv
// Latency counter for the outstanding access: load to 1 on issue, count while busy,
// done when the memory's fixed read latency has elapsed.
module rv32i_mem_arb_lat_cnt
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic load,
   input  logic clr,
   input  logic inc,
   output logic done
);
   logic [LAT_CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= LAT_CNT_W'(1);
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Counter idles at 0, so done can only fire while an access is outstanding.
   assign done = (cnt_reg == LAT_CNT_W'(MEM_LATENCY));

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter for one single-port fixed-latency memory; one access at a time.
// Define RV32I_MEM_ARB_PERF_EN to build the conflict / fetch-wait performance counters.
module rv32i_mem_arbiter
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2,
   parameter int STARVE_MAX  = 4
) (
   input logic                clk_i,
   input logic                resetn_i,
   rv32i_mem_arbiter_if.slave bus
);
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   arb_state_e          state_reg;
   logic                dm_store_reg;
   logic [STARVE_W-1:0] starve_reg;

   logic              lat_done;
   logic              busy;
   logic              window;
   logic              if_starved;
   logic              win_dm;
   logic              win_if;
   logic              grant;
   logic              owner;
   logic              if_done;
   logic              dm_done;
   logic              we_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic [3:0]        be_mux;

   assign busy = (state_reg != ARB_IDLE);
   // Qualifying with resetn_i keeps grants and stall low while reset is held.
   assign window     = resetn_i & (~busy | lat_done);
   assign if_starved = (starve_reg == STARVE_W'(STARVE_MAX));
   assign win_dm     = window & bus.dm_req_i & ~(bus.if_req_i & if_starved);
   assign win_if     = window & bus.if_req_i & ~win_dm;
   assign grant      = win_dm | win_if;
   assign owner      = win_dm ? ARB_OWNER_DM : ARB_OWNER_IF;
   assign if_done    = lat_done & (state_reg == ARB_BUSY_IF);
   assign dm_done    = lat_done & (state_reg == ARB_BUSY_DM);

   rv32i_mem_arb_lat_cnt #(.MEM_LATENCY(MEM_LATENCY)) u_lat_cnt (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .load     (grant),
      .clr      (lat_done & ~grant),
      .inc      (busy & ~lat_done),
      .done     (lat_done)
   );

   always_comb begin
      we_mux    = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      be_mux    = '0;
      if (grant) begin
         if (owner == ARB_OWNER_DM) begin
            we_mux    = bus.dm_we_i;
            addr_mux  = bus.dm_addr_i;
            wdata_mux = bus.dm_wdata_i;
            be_mux    = bus.dm_be_i;
         end else begin
            addr_mux = bus.if_addr_i;
            be_mux   = MEM_BE_ALL;
         end
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_reg    <= ARB_IDLE;
         dm_store_reg <= 1'b0;
         starve_reg   <= '0;
      end else begin
         if (grant) begin
            state_reg    <= owner_state(owner);
            dm_store_reg <= win_dm & bus.dm_we_i;
         end else if (lat_done) begin
            state_reg <= ARB_IDLE;
         end
         // Starvation count saturates; it is cleared only by an actual fetch grant.
         if (win_if) begin
            starve_reg <= '0;
         end else if (bus.if_req_i && !if_starved) begin
            starve_reg <= starve_reg + 1'b1;
         end
      end
   end

   assign bus.if_gnt_o    = win_if;
   assign bus.dm_gnt_o    = win_dm;
   assign bus.mem_req_o   = grant;
   assign bus.mem_we_o    = we_mux;
   assign bus.mem_addr_o  = addr_mux;
   assign bus.mem_wdata_o = wdata_mux;
   assign bus.mem_be_o    = be_mux;
   assign bus.if_rvalid_o = if_done;
   assign bus.if_rdata_o  = if_done ? bus.mem_rdata_i : '0;
   assign bus.dm_rvalid_o = dm_done;
   assign bus.dm_rdata_o  = (dm_done && !dm_store_reg) ? bus.mem_rdata_i : '0;
   assign bus.stall_o     = resetn_i & ((bus.if_req_i & ~win_if) | (bus.dm_req_i & ~win_dm) |
                                        ((state_reg == ARB_BUSY_DM) & ~dm_done));

`ifdef RV32I_MEM_ARB_PERF_EN
   logic [31:0] perf_conflict_reg;
   logic [31:0] perf_if_wait_reg;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         perf_conflict_reg <= '0;
         perf_if_wait_reg  <= '0;
      end else begin
         if (bus.if_req_i && bus.dm_req_i) begin
            perf_conflict_reg <= perf_conflict_reg + 32'd1;
         end
         if (bus.if_req_i && !win_if) begin
            perf_if_wait_reg <= perf_if_wait_reg + 32'd1;
         end
      end
   end

   assign bus.perf_conflict_o = perf_conflict_reg;
   assign bus.perf_if_wait_o  = perf_if_wait_reg;
`else
   assign bus.perf_conflict_o = '0;
   assign bus.perf_if_wait_o  = '0;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed vector table, corner sequences, random traffic vs. model.
// Perf expectations follow RV32I_MEM_ARB_PERF_EN.
module tb_rv32i_mem_arbiter;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic clk_i    = 1'b0;
   logic resetn_i = 1'b0;
   always #5 clk_i = ~clk_i;

   rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   rv32i_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .bus      (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] init_word(input int i);
      return 32'hA500_0000 ^ 32'(i << 2);
   endfunction

   // Memory device: writes on issue, read data appears LAT cycles after issue.
   logic [31:0] dev_mem [256];
   logic [31:0] rd_pipe [1:LAT];
   logic        dev_init = 1'b0;
   always @(posedge clk_i) begin
      if (!dev_init) begin
         for (int i = 0; i < 256; i++) dev_mem[i] = init_word(i);
         dev_init <= 1'b1;
      end else if (bus.mem_req_o && bus.mem_we_o) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be_o[b]) dev_mem[bus.mem_addr_o[9:2]][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
      end
      rd_pipe[1] <= (bus.mem_req_o && !bus.mem_we_o) ? dev_mem[bus.mem_addr_o[9:2]] : 32'h0;
      for (int k = 2; k <= LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bus.mem_rdata_i = rd_pipe[LAT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db);
      bus.if_req_i   = ir;
      bus.if_addr_i  = ia;
      bus.dm_req_i   = dr;
      bus.dm_we_i    = dw;
      bus.dm_addr_i  = da;
      bus.dm_wdata_i = dd;
      bus.dm_be_i    = db;
   endtask

   task automatic reset_dut();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      resetn_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      resetn_i = 1'b1;
   endtask

   typedef struct {
      logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd; logic [3:0] db;
      logic eig; logic edg; logic estall; logic emwe; logic [31:0] emaddr; logic [3:0] embe;
      logic eirv; logic edrv; logic [31:0] erdata;
   } vec_t;

   typedef struct {
      logic        owner_dm;
      logic [31:0] data;
      int          due;
   } resp_t;

   vec_t        tbl [17];
   resp_t       exp_q [$];
   logic [31:0] ref_mem [256];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [6:0]  sdm;
      logic [6:0]  sif;
      logic [31:0] exp_pc, exp_pw;
      logic        if_pend, dm_pend, dm_w, window, exp_if, exp_dm, dm_hold;
      logic [31:0] if_a, dm_a, dm_d;
      logic [3:0]  dm_b;
      int          starve_m, perf_c_m, perf_w_m;
      resp_t       r;

      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      //           ir  ia     dr  dw  da      dd            db      eig edg st  mwe maddr   mbe   irv drv rdata
      tbl[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   4'hF, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h4,   4'hF, 1'b1, 1'b0, 32'hA500_0000};
      tbl[3]  = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h8,   4'hF, 1'b1, 1'b0, 32'hA500_0004};
      tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b1, 1'b0, 32'hA500_0008};
      tbl[7]  = '{1'b1, 32'hC, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF,      1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hC,   4'hF, 1'b0, 1'b1, 32'hA500_0100};
      tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b1, 1'b0, 32'hA500_000C};
      tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 4'h3, 1'b0, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF,      1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 4'hF, 1'b0, 1'b1, 32'h0};
      tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 32'h0};
      tbl[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 1'b0, 1'b1, 32'hA500_BEEF};

      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      check("reset_if_gnt", 32'(bus.if_gnt_o), 32'h0);
      check("reset_stall", 32'(bus.stall_o), 32'h0);
      check("reset_mem_req", 32'(bus.mem_req_o), 32'h0);
      reset_dut();

      // Directed vector table: one row per clock cycle.
      for (int v = 0; v < 17; v++) begin
         @(negedge clk_i);
         drive(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dw, tbl[v].da, tbl[v].dd, tbl[v].db);
         #2;
         $display("vec %0d: if_gnt=%b dm_gnt=%b stall=%b if_rv=%b dm_rv=%b mem_addr=%08h",
                  v, bus.if_gnt_o, bus.dm_gnt_o, bus.stall_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.mem_addr_o);
         check("vec_if_gnt", 32'(bus.if_gnt_o), 32'(tbl[v].eig));
         check("vec_dm_gnt", 32'(bus.dm_gnt_o), 32'(tbl[v].edg));
         check("vec_mem_req", 32'(bus.mem_req_o), 32'(tbl[v].eig | tbl[v].edg));
         check("vec_stall", 32'(bus.stall_o), 32'(tbl[v].estall));
         check("vec_mem_we", 32'(bus.mem_we_o), 32'(tbl[v].emwe));
         check("vec_if_rvalid", 32'(bus.if_rvalid_o), 32'(tbl[v].eirv));
         check("vec_dm_rvalid", 32'(bus.dm_rvalid_o), 32'(tbl[v].edrv));
         if (tbl[v].eig || tbl[v].edg) begin
            check("vec_mem_addr", bus.mem_addr_o, tbl[v].emaddr);
            check("vec_mem_be", 32'(bus.mem_be_o), 32'(tbl[v].embe));
         end
         if (tbl[v].emwe) check("vec_mem_wdata", bus.mem_wdata_o, tbl[v].dd);
         if (tbl[v].eirv) check("vec_if_rdata", bus.if_rdata_o, tbl[v].erdata);
         if (tbl[v].edrv) check("vec_dm_rdata", bus.dm_rdata_o, tbl[v].erdata);
      end

      // Starvation: DM held continuously, IF pending; IF must win the 3rd window.
      sdm = 7'b1000101;
      sif = 7'b0010000;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk_i);
         drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
         #2;
         $display("starve cycle %0d: if_gnt=%b dm_gnt=%b", c, bus.if_gnt_o, bus.dm_gnt_o);
         check("starve_dm_gnt", 32'(bus.dm_gnt_o), 32'(sdm[c]));
         check("starve_if_gnt", 32'(bus.if_gnt_o), 32'(sif[c]));
      end
      @(negedge clk_i);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk_i);
      #2;
      check("starve_dm_rvalid", 32'(bus.dm_rvalid_o), 32'h1);
      check("starve_dm_rdata", bus.dm_rdata_o, 32'hA500_0010);

      // Asynchronous reset in the middle of a DM load.
      @(negedge clk_i);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      #2;
      check("rst_pre_dm_gnt", 32'(bus.dm_gnt_o), 32'h1);
      @(negedge clk_i);
      drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
      #1;
      resetn_i = 1'b0;
      #1;
      $display("async reset: if_gnt=%b dm_gnt=%b stall=%b", bus.if_gnt_o, bus.dm_gnt_o, bus.stall_o);
      check("rst_if_gnt", 32'(bus.if_gnt_o), 32'h0);
      check("rst_dm_gnt", 32'(bus.dm_gnt_o), 32'h0);
      check("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
      check("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
      check("rst_mem_addr", bus.mem_addr_o, 32'h0);
      check("rst_dm_rvalid", 32'(bus.dm_rvalid_o), 32'h0);
      check("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
      check("rst_stall", 32'(bus.stall_o), 32'h0);
      check("rst_perf_conflict", bus.perf_conflict_o, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      resetn_i = 1'b1;
      drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #2;
      check("post_rst_if_gnt", 32'(bus.if_gnt_o), 32'h1);
      check("post_rst_mem_addr", bus.mem_addr_o, 32'h40);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         #2;
         check("post_rst_no_dm_rvalid", 32'(bus.dm_rvalid_o), 32'h0);
      end

      // Three cycles of simultaneous requests.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h48, 32'h0, 4'hF);
      end
      @(negedge clk_i);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #2;
`ifdef RV32I_MEM_ARB_PERF_EN
      exp_pc = 32'd3; exp_pw = 32'd3;
`else
      exp_pc = 32'd0; exp_pw = 32'd0;
`endif
      $display("perf: conflict=%0d if_wait=%0d", bus.perf_conflict_o, bus.perf_if_wait_o);
      check("perf_conflict", bus.perf_conflict_o, exp_pc);
      check("perf_if_wait", bus.perf_if_wait_o, exp_pw);
      repeat (4) @(negedge clk_i);

      // Random traffic against a cycle-numbered response queue.
      reset_dut();
      if_pend = 1'b0; dm_pend = 1'b0; dm_w = 1'b0;
      if_a = '0; dm_a = '0; dm_d = '0; dm_b = '0;
      starve_m = 0; perf_c_m = 0; perf_w_m = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk_i);
         if (!if_pend) begin
            if ($urandom_range(0, 1) == 1) begin
               if_pend = 1'b1;
               if_a    = 32'($urandom_range(0, 63)) << 2;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            if_pend = 1'b0;
         end
         if (!dm_pend) begin
            if ($urandom_range(0, 2) == 0) begin
               dm_pend = 1'b1;
               dm_w    = 1'($urandom_range(0, 1));
               dm_a    = 32'($urandom_range(0, 63)) << 2;
               dm_d    = $urandom;
               dm_b    = 4'($urandom_range(1, 15));
            end
         end else if ($urandom_range(0, 15) == 0) begin
            dm_pend = 1'b0;
         end
         drive(if_pend, if_a, dm_pend, dm_w, dm_a, dm_d, dm_b);
         #2;

         window  = 1'b1;
         dm_hold = 1'b0;
         if (exp_q.size() != 0) begin
            window  = (exp_q[0].due == cyc);
            dm_hold = exp_q[0].owner_dm && (exp_q[0].due != cyc);
         end
         if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            check("rnd_if_rvalid", 32'(bus.if_rvalid_o), 32'(!r.owner_dm));
            check("rnd_dm_rvalid", 32'(bus.dm_rvalid_o), 32'(r.owner_dm));
            if (r.owner_dm) check("rnd_dm_rdata", bus.dm_rdata_o, r.data);
            else            check("rnd_if_rdata", bus.if_rdata_o, r.data);
         end else begin
            check("rnd_if_rvalid_idle", 32'(bus.if_rvalid_o), 32'h0);
            check("rnd_dm_rvalid_idle", 32'(bus.dm_rvalid_o), 32'h0);
         end

         exp_dm = window && dm_pend && !(if_pend && starve_m >= SMAX);
         exp_if = window && if_pend && !exp_dm;
         check("rnd_if_gnt", 32'(bus.if_gnt_o), 32'(exp_if));
         check("rnd_dm_gnt", 32'(bus.dm_gnt_o), 32'(exp_dm));
         check("rnd_mem_req", 32'(bus.mem_req_o), 32'(exp_if || exp_dm));
         check("rnd_stall", 32'(bus.stall_o),
               32'((if_pend && !exp_if) || (dm_pend && !exp_dm) || dm_hold));

         if (exp_dm) begin
            $display("rnd cyc %0d: DM %s addr=%08h be=%h", cyc, dm_w ? "store" : "load", dm_a, dm_b);
            check("rnd_dm_mem_addr", bus.mem_addr_o, dm_a);
            check("rnd_dm_mem_we", 32'(bus.mem_we_o), 32'(dm_w));
            check("rnd_dm_mem_be", 32'(bus.mem_be_o), 32'(dm_b));
            if (dm_w) begin
               check("rnd_dm_mem_wdata", bus.mem_wdata_o, dm_d);
               for (int b = 0; b < 4; b++)
                  if (dm_b[b]) ref_mem[dm_a[9:2]][8*b +: 8] = dm_d[8*b +: 8];
               exp_q.push_back('{1'b1, 32'h0, cyc + LAT});
            end else begin
               exp_q.push_back('{1'b1, ref_mem[dm_a[9:2]], cyc + LAT});
            end
            dm_pend = 1'b0;
         end
         if (exp_if) begin
            $display("rnd cyc %0d: IF fetch addr=%08h", cyc, if_a);
            check("rnd_if_mem_addr", bus.mem_addr_o, if_a);
            check("rnd_if_mem_we", 32'(bus.mem_we_o), 32'h0);
            exp_q.push_back('{1'b0, ref_mem[if_a[9:2]], cyc + LAT});
            if_pend = 1'b0;
         end

         if (if_pend && dm_pend) perf_c_m++;
         else if (bus.if_req_i && bus.dm_req_i) perf_c_m++;
         if (bus.if_req_i && !exp_if) perf_w_m++;
         if (exp_if) starve_m = 0;
         else if (bus.if_req_i && starve_m < SMAX) starve_m++;
      end
      @(negedge clk_i);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #2;
`ifdef RV32I_MEM_ARB_PERF_EN
      exp_pc = 32'(perf_c_m); exp_pw = 32'(perf_w_m);
`else
      exp_pc = 32'd0; exp_pw = 32'd0;
`endif
      check("rnd_perf_conflict", bus.perf_conflict_o, exp_pc);
      check("rnd_perf_if_wait", bus.perf_if_wait_o, exp_pw);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
